sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed driver for an N-digit common-anode seven-segment display. It converts a packed hex value into active-low segment and anode signals and scans the digits at a programmable refresh rate. A guard interval between digits prevents ghosting, and an atomic per-scan snapshot prevents tearing. It sits between any counter or datapath result and the board display pins, and replaces per-digit combinational decoders plus ad-hoc anode logic.

## Interface
- NUM_DIGITS, 4, digits driven; legal range 1..8.
- SLOT_CYCLES, 100000, clock cycles each digit slot lasts; must be > GUARD_CYCLES.
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes off; must be ≥ 1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  hex digits; digit k = value[4k+3:4k], digit 0 least significant.
- dp  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank  input  NUM_DIGITS  force digit k dark (segments, dp and anode off).
- lzb  input  1  leading-zero blanking enable.
- seg_L  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp_L  output  1  decimal point, active low.
- an_L  output  NUM_DIGITS  anode enables, active low, one-cold at most.

## Operation
- State:
  - slot counter cnt, width clog2(SLOT_CYCLES).
  - digit index idx, width clog2(NUM_DIGITS), min 1.
  - snapshot registers snap_val, snap_dp, snap_blank, snap_lzb.
- Counter: each non-reset cycle, if cnt == SLOT_CYCLES-1 then cnt←0 and idx←(idx == NUM_DIGITS-1 ? 0 : idx+1); else cnt←cnt+1. Scan order is digit 0, 1, …, N-1, then wrap.
- Snapshot: on any cycle where cnt == 0 and idx == 0 (start of scan, including the first cycle after reset), snap_* ← inputs. Input changes at any other time are not displayed until the next scan start.
- Glyphs, seg_L in gfedcba order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Dark = 1111111.
- Leading-zero blanking: when snap_lzb = 1, digit k (k ≥ 1) is dark if digit k and every digit above it are 0. Digit 0 is never lz-blanked.
- Dark digit (snap_blank[k], or lz-blanked): seg_L = 1111111, dp_L = 1, an_L[k] = 1 for its whole slot.
- Output function f(idx, cnt, snap):
  - seg_L = glyph of digit idx, or dark.
  - dp_L = ~snap_dp[idx], or 1 if the digit is dark.
  - an_L = all ones if cnt < GUARD_CYCLES or the digit is dark; otherwise only bit idx low.

## Timing
- All outputs are registered. The outputs on cycle t+1 equal f(idx, cnt, snap) as held on cycle t.
- Reset: cnt = 0, idx = 0, snap_* = 0, seg_L = 1111111, dp_L = 1, an_L = all ones. Reset values appear on the cycle after rst is sampled high, and reset mid-scan behaves the same way.
- One full scan lasts NUM_DIGITS × SLOT_CYCLES cycles. Each digit's anode is low for SLOT_CYCLES − GUARD_CYCLES consecutive cycles.
- A snapshot loaded at (idx 0, cnt 0) first drives the outputs one cycle later, while cnt < GUARD_CYCLES, so a lit anode never shows stale data.
- Segments change only while all anodes are off. Because GUARD_CYCLES ≥ 1, no two anodes are ever low on the same cycle.
- NUM_DIGITS = 1: idx stays at 0, and the snapshot reloads every slot.

## Structure
- Shared include sevenseg_defs holds:
  - the 16 glyph constants,
  - SEG_DARK = 7'b111_1111,
  - the clog2 helper function.
- Sub-module hex_glyph: purely combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed digit.
- The top level holds the counter, index, snapshot, blanking logic and output registers. It also carries parameter range checks that stop elaboration on illegal values.

## Test plan
- Params N=4, SLOT=8, GUARD=2, value=16'h12AF, lzb=0 → per slot:
  - digit 0 shows 0001110 with an_L=1110,
  - then 0001000 with an_L=1101,
  - then 0100100 with an_L=1011,
  - then 1111001 with an_L=0111.
  - Each anode is low exactly 6 cycles, and all anodes are high for 2 cycles at the start of each slot.
- value=16'h0005, lzb=1 → digits 3..1 dark with anodes never low; digit 0 shows 0010010. With value=16'h0000 and lzb=1, digit 0 shows 1000000.
- Change value from 16'h1111 to 16'h2222 while idx=2 → digits 2 and 3 still show 1 in that scan; all digits show 2 from the next scan.
- dp=4'b0100, blank=4'b0001 → dp_L=0 only in digit 2's slot; digit 0 fully dark with an_L[0] high.
- Assert rst for 1 cycle mid-slot of digit 3 → next cycle an_L=1111, seg_L=1111111, dp_L=1. The scan then restarts at digit 0 with a fresh snapshot.
- Param N=1, SLOT=4, GUARD=1 → an_L toggles 1,0,0,0 repeatedly. A value change appears within one slot.

Source files
------------

// File: rtl/sevenseg_scan_pkg.sv
// Shared definitions for the seven-segment scanner: glyph constants (active low,
// {g,f,e,d,c,b,a} order) and a clog2 helper usable in parameter expressions.
package sevenseg_scan_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b100_0000;
  localparam logic [6:0] GLYPH_1 = 7'b111_1001;
  localparam logic [6:0] GLYPH_2 = 7'b010_0100;
  localparam logic [6:0] GLYPH_3 = 7'b011_0000;
  localparam logic [6:0] GLYPH_4 = 7'b001_1001;
  localparam logic [6:0] GLYPH_5 = 7'b001_0010;
  localparam logic [6:0] GLYPH_6 = 7'b000_0010;
  localparam logic [6:0] GLYPH_7 = 7'b111_1000;
  localparam logic [6:0] GLYPH_8 = 7'b000_0000;
  localparam logic [6:0] GLYPH_9 = 7'b001_0000;
  localparam logic [6:0] GLYPH_A = 7'b000_1000;
  localparam logic [6:0] GLYPH_B = 7'b000_0011;
  localparam logic [6:0] GLYPH_C = 7'b100_0110;
  localparam logic [6:0] GLYPH_D = 7'b010_0001;
  localparam logic [6:0] GLYPH_E = 7'b000_0110;
  localparam logic [6:0] GLYPH_F = 7'b000_1110;

  localparam logic [6:0] SEG_DARK = 7'b111_1111;

  // Smallest w with 2**w >= value; 0 and 1 both give 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/hex_glyph.sv
// Combinational hex digit to active-low seven-segment glyph decoder.
module hex_glyph
  import sevenseg_scan_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DARK;
    case (digit_i)
      4'h0:    seg_o = GLYPH_0;
      4'h1:    seg_o = GLYPH_1;
      4'h2:    seg_o = GLYPH_2;
      4'h3:    seg_o = GLYPH_3;
      4'h4:    seg_o = GLYPH_4;
      4'h5:    seg_o = GLYPH_5;
      4'h6:    seg_o = GLYPH_6;
      4'h7:    seg_o = GLYPH_7;
      4'h8:    seg_o = GLYPH_8;
      4'h9:    seg_o = GLYPH_9;
      4'hA:    seg_o = GLYPH_A;
      4'hB:    seg_o = GLYPH_B;
      4'hC:    seg_o = GLYPH_C;
      4'hD:    seg_o = GLYPH_D;
      4'hE:    seg_o = GLYPH_E;
      default: seg_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver with per-slot guard interval
// and a snapshot of the inputs taken once per full scan to avoid tearing.
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lzb,
  output logic [6:0]              seg_L,
  output logic                    dp_L,
  output logic [NUM_DIGITS-1:0]   an_L
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gen_bad_num_digits
    $fatal(1, "sevenseg_scan: NUM_DIGITS must be in 1..8");
  end
  if (GUARD_CYCLES < 1) begin : gen_bad_guard
    $fatal(1, "sevenseg_scan: GUARD_CYCLES must be at least 1");
  end
  if (SLOT_CYCLES <= GUARD_CYCLES) begin : gen_bad_slot
    $fatal(1, "sevenseg_scan: SLOT_CYCLES must exceed GUARD_CYCLES");
  end

  localparam int unsigned CntW    = clog2(SLOT_CYCLES);
  localparam int unsigned IdxWRaw = clog2(NUM_DIGITS);
  localparam int unsigned IdxW    = (IdxWRaw < 1) ? 1 : IdxWRaw;

  localparam logic [CntW-1:0] CntLast  = CntW'(SLOT_CYCLES - 1);
  localparam logic [CntW-1:0] CntGuard = CntW'(GUARD_CYCLES);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_val_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_blank_q;
  logic                    snap_lzb_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       scan_start;
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_blank;
  logic       lz_dark;
  logic       zero_run;
  logic       dark;
  logic       lit;
  logic [6:0] glyph_seg;

  assign scan_start = (cnt_q == '0) && (idx_q == '0);

  always_comb begin
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_digit = snap_val_q[4*k +: 4];
        cur_dp    = snap_dp_q[k];
        cur_blank = snap_blank_q[k];
      end
    end
  end

  // Walk from the most significant digit down; zero_run stays set while every
  // digit at or above k is zero. Digit 0 is never leading-zero blanked.
  always_comb begin
    lz_dark  = 1'b0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run = zero_run && (snap_val_q[4*k +: 4] == 4'h0);
      if ((k != 0) && (idx_q == IdxW'(k)) && zero_run) begin
        lz_dark = snap_lzb_q;
      end
    end
  end

  hex_glyph u_hex_glyph (
    .digit_i (cur_digit),
    .seg_o   (glyph_seg)
  );

  assign dark = cur_blank || lz_dark;
  assign lit  = !dark && (cnt_q >= CntGuard);

  always_comb begin
    seg_d = dark ? SEG_DARK : glyph_seg;
    dp_d  = dark | ~cur_dp;
    an_d  = '1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (lit && (idx_q == IdxW'(k))) begin
        an_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      snap_lzb_q   <= 1'b0;
      seg_q        <= SEG_DARK;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      if (scan_start) begin
        snap_val_q   <= value;
        snap_dp_q    <= dp;
        snap_blank_q <= blank;
        snap_lzb_q   <= lzb;
      end
    end
  end

  assign seg_L = seg_q;
  assign dp_L  = dp_q;
  assign an_L  = an_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench: two scanner instances (4 digits and 1 digit) checked every
// cycle against a cycle-count based reference model, plus anode run-length checks.
module tb_sevenseg_scan;

  localparam int N0 = 4;
  localparam int S0 = 8;
  localparam int G0 = 2;
  localparam int N1 = 1;
  localparam int S1 = 4;
  localparam int G1 = 1;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] value0;
  logic [3:0]  dp0, blank0;
  logic        lzb0;
  logic [6:0]  seg0;
  logic        dpl0;
  logic [3:0]  an0;

  logic [3:0]  value1;
  logic [0:0]  dp1, blank1;
  logic        lzb1;
  logic [6:0]  seg1;
  logic        dpl1;
  logic [0:0]  an1;

  int checks = 0;
  int errs   = 0;
  int p0     = 0;
  int p1     = 0;
  out_t q0[$];
  out_t q1[$];

  logic [6:0] glyph_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  sevenseg_scan #(
    .NUM_DIGITS   (N0),
    .SLOT_CYCLES  (S0),
    .GUARD_CYCLES (G0)
  ) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .value (value0),
    .dp    (dp0),
    .blank (blank0),
    .lzb   (lzb0),
    .seg_L (seg0),
    .dp_L  (dpl0),
    .an_L  (an0)
  );

  sevenseg_scan #(
    .NUM_DIGITS   (N1),
    .SLOT_CYCLES  (S1),
    .GUARD_CYCLES (G1)
  ) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .value (value1),
    .dp    (dp1),
    .blank (blank1),
    .lzb   (lzb1),
    .seg_L (seg1),
    .dp_L  (dpl1),
    .an_L  (an1)
  );

  // What the display shows for digit s at position pos within its slot.
  function automatic out_t model_f(input int guard, input int s, input int pos,
                                   input logic [31:0] v, input logic [7:0] dpv,
                                   input logic [7:0] bl, input logic lz);
    out_t o;
    logic dark;
    logic [3:0] d;
    d = v[4*s +: 4];
    dark = bl[s] || (lz && (s != 0) && ((v >> (4*s)) == 32'd0));
    o.seg = dark ? 7'h7f : glyph_tbl[d];
    o.dp  = dark ? 1'b1 : ~dpv[s];
    o.an  = 8'hff;
    if (!dark && pos >= guard) o.an[s] = 1'b0;
    return o;
  endfunction

  // Model: p counts cycles since the last reset modulo one scan.
  initial begin : model0
    logic [31:0] sv;
    logic [7:0]  sdp, sbl;
    logic        slz;
    bit          started;
    sv = '0; sdp = '0; sbl = '0; slz = 1'b0; started = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q0.push_back(out_t'{seg: 7'h7f, dp: 1'b1, an: 8'hff});
        p0 = 0; sv = '0; sdp = '0; sbl = '0; slz = 1'b0; started = 1'b1;
      end else if (started) begin
        q0.push_back(model_f(G0, p0 / S0, p0 % S0, sv, sdp, sbl, slz));
        if (p0 == 0) begin
          sv = 32'(value0); sdp = 8'(dp0); sbl = 8'(blank0); slz = lzb0;
        end
        p0 = (p0 + 1) % (N0 * S0);
      end
    end
  end

  initial begin : model1
    logic [31:0] sv;
    logic [7:0]  sdp, sbl;
    logic        slz;
    bit          started;
    sv = '0; sdp = '0; sbl = '0; slz = 1'b0; started = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q1.push_back(out_t'{seg: 7'h7f, dp: 1'b1, an: 8'hff});
        p1 = 0; sv = '0; sdp = '0; sbl = '0; slz = 1'b0; started = 1'b1;
      end else if (started) begin
        q1.push_back(model_f(G1, p1 / S1, p1 % S1, sv, sdp, sbl, slz));
        if (p1 == 0) begin
          sv = 32'(value1); sdp = 8'(dp1); sbl = 8'(blank1); slz = lzb1;
        end
        p1 = (p1 + 1) % (N1 * S1);
      end
    end
  end

  initial begin : monitor0
    out_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if ({seg0, dpl0, an0} !== {e.seg, e.dp, e.an[3:0]}) begin
          errs++;
          $display("FAIL dut0_out t=%0t got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                   $time, seg0, dpl0, an0, e.seg, e.dp, e.an[3:0]);
        end
      end
    end
  end

  initial begin : monitor1
    out_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if ({seg1, dpl1, an1} !== {e.seg, e.dp, e.an[0]}) begin
          errs++;
          $display("FAIL dut1_out t=%0t got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                   $time, seg1, dpl1, an1, e.seg, e.dp, e.an[0]);
        end
      end
    end
  end

  // Every uninterrupted anode-low run must last SLOT-GUARD cycles; one-cold at most.
  initial begin : run_check
    int run;
    bit taint;
    run = 0;
    taint = 1'b1;
    forever begin
      @(negedge clk);
      if (!$isunknown(an0)) begin
        checks++;
        if ($countones(~an0) > 1) begin
          errs++;
          $display("FAIL one_cold t=%0t got an=%b expected at most one low bit", $time, an0);
        end
        if (an0 == 4'hf) begin
          if (run > 0 && !taint) begin
            checks++;
            if (run != S0 - G0) begin
              errs++;
              $display("FAIL anode_run t=%0t got %0d cycles expected %0d", $time, run, S0 - G0);
            end
          end
          run = 0;
        end else begin
          if (run == 0) taint = rst;
          run++;
        end
        if (rst) taint = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_p0(input int target);
    int i;
    i = 0;
    while (p0 != target && i < 200) begin
      tick(1);
      i++;
    end
    checks++;
    if (p0 != target) begin
      errs++;
      $display("FAIL phase_wait got position %0d expected %0d", p0, target);
    end
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    end
    return r;
  endfunction

  initial begin : stim
    value0 = 16'h12AF; dp0 = 4'b0000; blank0 = 4'b0000; lzb0 = 1'b0;
    value1 = 4'h3; dp1 = 1'b0; blank1 = 1'b0; lzb1 = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * N0 * S0);
    value0 = 16'h0005; lzb0 = 1'b1;
    tick(2 * N0 * S0);
    value0 = 16'h0000; lzb1 = 1'b1; value1 = 4'h0;
    tick(2 * N0 * S0);
    value0 = 16'h1111; lzb0 = 1'b0; value1 = 4'h9;
    tick(40);
    wait_p0(2 * S0 + 2);
    value0 = 16'h2222; value1 = 4'hC;
    tick(2 * N0 * S0);
    dp0 = 4'b0100; blank0 = 4'b0001; value0 = 16'h8E3D; dp1 = 1'b1;
    tick(2 * N0 * S0);
    wait_p0(3 * S0 + 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; dp0 = 4'b0000; blank0 = 4'b0000;
    tick(2 * N0 * S0);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        value0 = rand_val();
        dp0    = 4'($urandom);
        blank0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        lzb0   = 1'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        value1 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        dp1    = 1'($urandom);
        blank1 = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
        lzb1   = 1'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule
